// File: rtl/mips_run_monitor_pkg.sv
// Shared types for the MIPS run monitor.
// State encoding and the default boot address.
package mips_run_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALT    = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF =
    32'hBFC00000;

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating up-counter with synchronous load.
// Holds at all-ones once reached.
module mips_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  // load wins over increment; stop at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mips_cpu_run_monitor.sv
// Watches CPU status: start, halt, runaway, counts.
// Optional PC history: RUN_MONITOR_PC_HIST_EN.
module mips_cpu_run_monitor
  import mips_run_monitor_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR =
    RESET_VECTOR_DEF,
  parameter int MAX_CYCLES = 200,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             active,
  input  logic [31:0]      instr_address,
  input  logic [31:0]      register_v0,
  input  logic             check_en,
  input  logic [31:0]      expected_v0,
`ifdef RUN_MONITOR_PC_HIST_EN
  input  logic [1:0]       hist_sel,
  output logic [31:0]      hist_pc,
`endif
  output logic             done,
  output logic             timeout,
  output logic             pass,
  output logic [31:0]      v0_final,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] fetch_count,
  output mon_state_t       state
);

  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(MAX_CYCLES);

  mon_state_t       r_state;
  mon_state_t       w_next;
  logic [31:0]      r_prev;
  logic [31:0]      r_v0;
  logic             r_done;
  logic             r_to;
  logic             r_pass;
  logic             w_arm;
  logic             w_halt;
  logic             w_tmo;
  logic             w_count;
  logic             w_new;
  logic             w_fetch;
  logic [CNT_W-1:0] w_cyc;
  logic [CNT_W-1:0] w_fet;

  // next state; counting only on RUN edges that stay in RUN
  always_comb begin
    w_next  = r_state;
    w_arm   = 1'b0;
    w_halt  = 1'b0;
    w_tmo   = 1'b0;
    w_count = 1'b0;
    w_new   = (instr_address != r_prev);
    unique case (r_state)
      IDLE: begin
        if (active &&
            (instr_address == RESET_VECTOR)) begin
          w_arm  = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        if (!active && (instr_address == '0)) begin
          w_halt = 1'b1;
          w_next = HALT;
        end else if (w_cyc == MAX_C) begin
          w_tmo  = 1'b1;
          w_next = TIMEOUT;
        end else begin
          w_count = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign w_fetch = clk_enable & w_count & w_new;

  mips_sat_counter #(.W(CNT_W)) u_cyc (
    .clk      (clk),
    .reset    (reset),
    .en       (clk_enable & w_count),
    .load     (clk_enable & w_arm),
    .load_val (CNT_W'(1)),
    .q        (w_cyc)
  );

  mips_sat_counter #(.W(CNT_W)) u_fet (
    .clk      (clk),
    .reset    (reset),
    .en       (w_fetch),
    .load     (clk_enable & w_arm),
    .load_val (CNT_W'(1)),
    .q        (w_fet)
  );

  // state register, frozen while the CPU clock is gated
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else if (clk_enable) begin
      r_state <= w_next;
    end
  end

  // last fetch address, used to spot distinct fetches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= '0;
    end else if (clk_enable &&
                 (w_arm || (w_count && w_new))) begin
      r_prev <= instr_address;
    end
  end

  // sticky verdict registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
      r_to   <= 1'b0;
      r_pass <= 1'b0;
      r_v0   <= '0;
    end else if (clk_enable) begin
      if (w_halt) begin
        r_done <= 1'b1;
        r_v0   <= register_v0;
        r_pass <= !check_en ||
                  (register_v0 == expected_v0);
      end else if (w_tmo) begin
        r_to   <= 1'b1;
        r_pass <= 1'b0;
      end
    end
  end

`ifdef RUN_MONITOR_PC_HIST_EN
  logic [31:0] r_hist [4];

  // newest distinct fetch address lands in slot 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_hist[i] <= '0;
      end
    end else if (w_fetch) begin
      r_hist[0] <= instr_address;
      r_hist[1] <= r_hist[0];
      r_hist[2] <= r_hist[1];
      r_hist[3] <= r_hist[2];
    end
  end

  assign hist_pc = r_hist[hist_sel];
`endif

  assign done        = r_done;
  assign timeout     = r_to;
  assign pass        = r_pass;
  assign v0_final    = r_v0;
  assign cycle_count = w_cyc;
  assign fetch_count = w_fet;
  assign state       = r_state;

endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// Scoreboard bench for mips_cpu_run_monitor.
// Directed programs; monitor compares at negedge.
`timescale 1ns/1ps
module tb_mips_cpu_run_monitor;
  import mips_run_monitor_pkg::*;

  localparam logic [31:0] RV = 32'hBFC00000;

  typedef enum int {
    F_DONE, F_TO, F_PASS, F_V0,
    F_CC, F_FC, F_ST, F_HP
  } fld_e;

  typedef struct {
    string       nm;
    fld_e        f;
    logic [31:0] e;
  } sb_t;

  sb_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic        active = 1'b0;
  logic [31:0] instr_address = '0;
  logic [31:0] register_v0 = '0;
  logic        check_en = 1'b0;
  logic [31:0] expected_v0 = '0;
  logic        done;
  logic        timeout;
  logic        pass;
  logic [31:0] v0_final;
  logic [15:0] cycle_count;
  logic [15:0] fetch_count;
  mon_state_t  st;
`ifdef RUN_MONITOR_PC_HIST_EN
  logic [1:0]  hist_sel = 2'd0;
  logic [31:0] hist_pc;
`endif

  mips_cpu_run_monitor dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .active        (active),
    .instr_address (instr_address),
    .register_v0   (register_v0),
    .check_en      (check_en),
    .expected_v0   (expected_v0),
`ifdef RUN_MONITOR_PC_HIST_EN
    .hist_sel      (hist_sel),
    .hist_pc       (hist_pc),
`endif
    .done          (done),
    .timeout       (timeout),
    .pass          (pass),
    .v0_final      (v0_final),
    .cycle_count   (cycle_count),
    .fetch_count   (fetch_count),
    .state         (st)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] act(fld_e f);
    case (f)
      F_DONE: return {31'b0, done};
      F_TO:   return {31'b0, timeout};
      F_PASS: return {31'b0, pass};
      F_V0:   return v0_final;
      F_CC:   return {16'b0, cycle_count};
      F_FC:   return {16'b0, fetch_count};
      F_ST:   return {30'b0, st};
`ifdef RUN_MONITOR_PC_HIST_EN
      F_HP:   return hist_pc;
`endif
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  initial begin : monitor
    sb_t         x;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        x = sb.pop_front();
        a = act(x.f);
        checks++;
        if (a !== x.e) begin
          failures++;
          $display("FAIL %s: got %h expected %h",
                   x.nm, a, x.e);
        end
      end
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: bench did not end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(string n, fld_e f,
                     logic [31:0] e);
    sb.push_back('{n, f, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(logic a, logic [31:0] ad);
    active        = a;
    instr_address = ad;
  endtask

  task automatic hard_reset();
    sync();
    reset = 1'b0;
    drv(1'b0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic run_prog(logic [31:0] ev,
                          logic ce);
    expected_v0 = ev;
    check_en    = ce;
    register_v0 = 32'd6;
    drv(1'b1, RV);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, RV + 32'(4 * i));
      tick();
    end
    drv(1'b0, 32'h0);
    tick();
  endtask

  task automatic to_run_08();
    drv(1'b1, RV);
    tick();
    drv(1'b1, RV + 32'h4);
    tick();
    drv(1'b1, RV + 32'h8);
    tick();
  endtask

  initial begin : stim
    tick();
    tick();
    chk("rst_state", F_ST, 32'(IDLE));
    chk("rst_done",  F_DONE, 0);
    chk("rst_cc",    F_CC, 0);
    chk("rst_fc",    F_FC, 0);
    chk("rst_v0",    F_V0, 0);
    sync();
    reset = 1'b1;
    tick();
    chk("idle_wait", F_ST, 32'(IDLE));

    // 1: clean halt with matching v0
    run_prog(32'd6, 1'b1);
    chk("t1_done",  F_DONE, 1);
    chk("t1_pass",  F_PASS, 1);
    chk("t1_fc",    F_FC, 5);
    chk("t1_cc",    F_CC, 5);
    chk("t1_v0",    F_V0, 6);
    chk("t1_to",    F_TO, 0);
    chk("t1_state", F_ST, 32'(HALT));
    drv(1'b1, RV);
    register_v0 = 32'd9;
    for (int i = 0; i < 3; i++) tick();
    chk("t1_frz_st", F_ST, 32'(HALT));
    chk("t1_frz_cc", F_CC, 5);
    chk("t1_frz_v0", F_V0, 6);
`ifdef RUN_MONITOR_PC_HIST_EN
    sync();
    hist_sel = 2'd0;
    chk("hist0", F_HP, RV + 32'h10);
    sync();
    hist_sel = 2'd1;
    chk("hist1", F_HP, RV + 32'hC);
    sync();
    hist_sel = 2'd3;
    chk("hist3", F_HP, RV + 32'h4);
    sync();
`endif

    // 2: v0 mismatch, then check disabled
    hard_reset();
    run_prog(32'd7, 1'b1);
    chk("t2_done", F_DONE, 1);
    chk("t2_pass", F_PASS, 0);
    chk("t2_v0",   F_V0, 6);
    hard_reset();
    run_prog(32'd7, 1'b0);
    chk("t2_nochk", F_PASS, 1);

    // 3: runaway at a fixed address
    hard_reset();
    to_run_08();
    for (int i = 0; i < 197; i++) tick();
    chk("t3_cc200", F_CC, 200);
    chk("t3_run",   F_ST, 32'(RUN));
    chk("t3_noto",  F_TO, 0);
    tick();
    chk("t3_to",    F_TO, 1);
    chk("t3_state", F_ST, 32'(TIMEOUT));
    chk("t3_cc",    F_CC, 200);
    chk("t3_fc",    F_FC, 3);
    chk("t3_done",  F_DONE, 0);
    chk("t3_pass",  F_PASS, 0);

    // 4: halt on the timeout cycle
    hard_reset();
    to_run_08();
    for (int i = 0; i < 197; i++) tick();
    expected_v0 = 32'd6;
    check_en    = 1'b1;
    register_v0 = 32'd6;
    drv(1'b0, 32'h0);
    tick();
    chk("t4_done",  F_DONE, 1);
    chk("t4_to",    F_TO, 0);
    chk("t4_state", F_ST, 32'(HALT));
    chk("t4_pass",  F_PASS, 1);

    // 5: short async reset pulse mid-run
    hard_reset();
    to_run_08();
    chk("t5_pre_cc", F_CC, 3);
    sync();
    drv(1'b1, RV + 32'h4);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    chk("t5_st",   F_ST, 32'(IDLE));
    chk("t5_cc",   F_CC, 0);
    chk("t5_fc",   F_FC, 0);
    tick();
    chk("t5_idle", F_ST, 32'(IDLE));
    drv(1'b1, RV);
    tick();
    chk("t5_rearm", F_ST, 32'(RUN));
    chk("t5_cc1",   F_CC, 1);
    chk("t5_fc1",   F_FC, 1);

    // 6: clock enable gating in RUN
    drv(1'b1, RV + 32'h4);
    tick();
    sync();
    clk_enable = 1'b0;
    drv(1'b0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    chk("t6_cc",   F_CC, 2);
    chk("t6_fc",   F_FC, 2);
    chk("t6_st",   F_ST, 32'(RUN));
    chk("t6_done", F_DONE, 0);
    sync();
    clk_enable = 1'b1;
    drv(1'b1, RV + 32'h8);
    tick();
    chk("t6_cc3", F_CC, 3);
    drv(1'b0, RV + 32'hC);
    tick();
    chk("t6_inact_st", F_ST, 32'(RUN));
    chk("t6_inact_fc", F_FC, 4);
    drv(1'b1, RV + 32'hC);
    tick();
    chk("t6_same_cc", F_CC, 5);
    chk("t6_same_fc", F_FC, 4);

    tick();
    tick();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending expected 0",
               sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
